// File: rtl/mul_div_unit.sv
// HI/LO unit for the EX stage: iterative radix-2 multiply/divide, MTHI/MTLO/MFHI/MFLO,
// and pipeline stall generation while a multiply or divide is in flight.
module mul_div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [5:0]            funct_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] op_a_i,
  input  logic [DATA_WIDTH-1:0] op_b_i,
  input  logic                  flush_i,
  output logic                  stall_o,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic [DATA_WIDTH-1:0] hi_o,
  output logic [DATA_WIDTH-1:0] lo_o
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  localparam logic [5:0] F_MFHI = 6'h10;
  localparam logic [5:0] F_MTHI = 6'h11;
  localparam logic [5:0] F_MFLO = 6'h12;
  localparam logic [5:0] F_MTLO = 6'h13;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [W-1:0]    acc_hi_q;   // product upper half / partial remainder
  logic [W-1:0]    acc_lo_q;   // multiplier bits / dividend shifting into quotient
  logic [W-1:0]    opnd_q;     // multiplicand or divisor magnitude
  logic            is_div_q, sa_q, sb_q, dz_q;
  logic [W-1:0]    hi_q, lo_q;

  logic            accept, is_muldiv, start;
  logic            start_div, start_signed, sa_in, sb_in, dz_in;
  logic [W-1:0]    a_mag, b_mag;
  logic [W:0]      mul_sum;
  logic [W:0]      div_shift;
  logic [W-1:0]    div_diff;
  logic            div_ok;
  logic            neg_q, neg_r;
  logic [2*W-1:0]  prod, prod_neg;
  logic [W-1:0]    fix_hi, fix_lo;
  logic            wr_fix;

  // MULT/MULTU/DIV/DIVU occupy 18h..1Bh: bit 1 selects divide, bit 0 selects unsigned.
  assign accept       = valid_i & ~flush_i;
  assign is_muldiv    = (funct_i[5:2] == 4'b0110);
  assign start        = (state_q == S_IDLE) & accept & is_muldiv;
  assign start_div    = funct_i[1];
  assign start_signed = ~funct_i[0];
  assign sa_in        = start_signed & op_a_i[W-1];
  assign sb_in        = start_signed & op_b_i[W-1];
  assign a_mag        = sa_in ? -op_a_i : op_a_i;
  assign b_mag        = sb_in ? -op_b_i : op_b_i;
  assign dz_in        = start_div & (op_b_i == '0);

  assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
  assign div_shift = {acc_hi_q, acc_lo_q[W-1]};
  assign div_ok    = (div_shift >= {1'b0, opnd_q});
  // The true difference is below the divisor whenever it is kept, so W bits suffice.
  assign div_diff  = div_shift[W-1:0] - opnd_q;

  // A zero divisor ran on the raw dividend, so its result is left uncorrected.
  assign neg_q    = (sa_q ^ sb_q) & ~dz_q;
  assign neg_r    = sa_q & ~dz_q;
  assign prod     = {acc_hi_q, acc_lo_q};
  assign prod_neg = -prod;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first; a path that
    // leaves a signal unassigned infers a latch.
    fix_hi = acc_hi_q;
    fix_lo = acc_lo_q;
    if (is_div_q) begin
      if (neg_r) fix_hi = -acc_hi_q;
      if (neg_q) fix_lo = -acc_lo_q;
    end else if (neg_q) begin
      {fix_hi, fix_lo} = prod_neg;
    end
  end

  always_comb begin
    state_d = state_q;
    stall_o = 1'b0;
    wr_fix  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CALC;
          stall_o = 1'b1;
        end
      end
      S_CALC: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          stall_o = 1'b1;
          if (cnt_q == CW'(W - 1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        wr_fix  = ~flush_i;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_q == S_CALC) ? cnt_q + 1'b1 : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      dz_q     <= 1'b0;
    end else if (start) begin
      acc_hi_q <= '0;
      acc_lo_q <= start_div ? (dz_in ? op_a_i : a_mag) : b_mag;
      opnd_q   <= start_div ? b_mag : a_mag;
      is_div_q <= start_div;
      sa_q     <= sa_in;
      sb_q     <= sb_in;
      dz_q     <= dz_in;
    end else if (state_q == S_CALC) begin
      if (is_div_q) begin
        acc_hi_q <= div_ok ? div_diff : div_shift[W-1:0];
        acc_lo_q <= {acc_lo_q[W-2:0], div_ok};
      end else begin
        acc_hi_q <= mul_sum[W:1];
        acc_lo_q <= {mul_sum[0], acc_lo_q[W-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (wr_fix) begin
      hi_q <= fix_hi;
      lo_q <= fix_lo;
    end else if ((state_q == S_IDLE) && accept) begin
      if (funct_i == F_MTHI) hi_q <= op_a_i;
      if (funct_i == F_MTLO) lo_q <= op_a_i;
    end
  end

  always_comb begin
    result_o = '0;
    if (valid_i && funct_i == F_MFHI) result_o = hi_q;
    if (valid_i && funct_i == F_MFLO) result_o = lo_q;
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases plus random multiply/divide
// traffic compared against a plain-arithmetic reference model.
module tb_mul_div_unit;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  funct_i = '0;
  logic        valid_i = 1'b0;
  logic [31:0] op_a_i = '0;
  logic [31:0] op_b_i = '0;
  logic        flush_i = 1'b0;
  logic        stall_o;
  logic [31:0] result_o, hi_o, lo_o;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  always #5 clk = ~clk;

  mul_div_unit #(.DATA_WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .funct_i  (funct_i),
    .valid_i  (valid_i),
    .op_a_i   (op_a_i),
    .op_b_i   (op_b_i),
    .flush_i  (flush_i),
    .stall_o  (stall_o),
    .result_o (result_o),
    .hi_o     (hi_o),
    .lo_o     (lo_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled 1 ns later.
  task automatic drive(input logic [5:0] f, input logic v, input logic [31:0] a,
                       input logic [31:0] b, input logic fl);
    @(negedge clk);
    funct_i = f; valid_i = v; op_a_i = a; op_b_i = b; flush_i = fl;
    #1;
  endtask

  // Architectural HI/LO results, straight from the instruction definitions.
  function automatic void ref_model(input logic [5:0] f, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] hi,
                                    output logic [31:0] lo);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    case (f)
      F_MULT:  p = 64'(sa * sb);
      F_MULTU: p = {32'h0, a} * {32'h0, b};
      F_DIV, F_DIVU: begin
        if (b == 32'h0) begin
          p = {a, 32'hFFFF_FFFF};
        end else if (f == F_DIV) begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end else begin
          p = {a % b, a / b};
        end
      end
      default: p = '0;
    endcase
    hi = p[63:32];
    lo = p[31:0];
  endfunction

  // Issues one multiply/divide, holds it in EX while stalled, then checks the outcome.
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    int          n;
    logic [31:0] nh, nl;
    ref_model(f, a, b, nh, nl);
    drive(f, 1'b1, a, b, 1'b0);
    n = 0;
    while (stall_o === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    check({tag, " stall_cycles"}, 64'(n), 64'd33);
    check({tag, " hi_before_write"}, 64'(hi_o), 64'(exp_hi));
    drive(6'h00, 1'b0, '0, '0, 1'b0);
    exp_hi = nh;
    exp_lo = nl;
    check({tag, " hi"}, 64'(hi_o), 64'(exp_hi));
    check({tag, " lo"}, 64'(lo_o), 64'(exp_lo));
    check({tag, " no_restart"}, 64'(stall_o), 64'd0);
  endtask

  initial begin
    logic [5:0]  rf;
    logic [31:0] ra, rb;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("reset hi", 64'(hi_o), 64'd0);
    check("reset lo", 64'(lo_o), 64'd0);
    check("reset stall", 64'(stall_o), 64'd0);
    check("reset result", 64'(result_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Unsigned and signed multiply
    run_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    check("multu_max const_hi", 64'(hi_o), 64'hFFFF_FFFE);
    check("multu_max const_lo", 64'(lo_o), 64'h0000_0001);
    run_op(F_MULT, 32'hFFFF_FFFE, 32'h0000_0003, "mult_neg");
    drive(F_MFLO, 1'b1, '0, '0, 1'b0);
    check("mflo after mult", 64'(result_o), 64'hFFFF_FFFA);
    check("mflo no stall", 64'(stall_o), 64'd0);
    drive(F_MFHI, 1'b1, '0, '0, 1'b0);
    check("mfhi after mult", 64'(result_o), 64'hFFFF_FFFF);

    // Divide: signed, by zero, overflow
    run_op(F_DIV, 32'hFFFF_FFF9, 32'h0000_0002, "div_neg");
    check("div_neg const_lo", 64'(lo_o), 64'hFFFF_FFFD);
    check("div_neg const_hi", 64'(hi_o), 64'hFFFF_FFFF);
    run_op(F_DIVU, 32'h0000_0007, 32'h0000_0000, "divu_zero");
    check("divu_zero const_lo", 64'(lo_o), 64'hFFFF_FFFF);
    check("divu_zero const_hi", 64'(hi_o), 64'h0000_0007);
    run_op(F_DIV, 32'hFFFF_FFF9, 32'h0000_0000, "div_zero_neg");
    run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    check("div_ovf const_lo", 64'(lo_o), 64'h8000_0000);
    check("div_ovf const_hi", 64'(hi_o), 64'h0000_0000);

    // MTHI / MTLO and moves-from
    drive(F_MTHI, 1'b1, 32'h1234_5678, '0, 1'b0);
    check("mthi stall", 64'(stall_o), 64'd0);
    drive(F_MFHI, 1'b1, '0, '0, 1'b0);
    exp_hi = 32'h1234_5678;
    check("mfhi after mthi", 64'(result_o), 64'h1234_5678);
    check("mfhi stall", 64'(stall_o), 64'd0);
    check("lo untouched by mthi", 64'(lo_o), 64'(exp_lo));
    drive(F_MTLO, 1'b1, 32'hCAFE_F00D, '0, 1'b0);
    drive(F_MFLO, 1'b1, '0, '0, 1'b0);
    exp_lo = 32'hCAFE_F00D;
    check("mflo after mtlo", 64'(result_o), 64'(exp_lo));
    check("hi untouched by mtlo", 64'(hi_o), 64'(exp_hi));

    // Flush in IDLE, unknown funct, valid low
    drive(F_MTHI, 1'b1, 32'hDEAD_BEEF, '0, 1'b1);
    drive(F_MFHI, 1'b1, '0, '0, 1'b0);
    check("flushed mthi ignored", 64'(result_o), 64'(exp_hi));
    drive(F_MULT, 1'b1, 32'h5, 32'h7, 1'b1);
    check("flushed start no stall", 64'(stall_o), 64'd0);
    drive(F_MULT, 1'b0, 32'h5, 32'h7, 1'b0);
    check("no start when invalid", 64'(stall_o), 64'd0);
    drive(6'h20, 1'b1, 32'h5, 32'h7, 1'b0);
    check("other funct result", 64'(result_o), 64'd0);
    drive(F_MFLO, 1'b0, '0, '0, 1'b0);
    check("mflo invalid result", 64'(result_o), 64'd0);

    // Flush at CALC cycle 10
    drive(F_MULTU, 1'b1, 32'h0001_0000, 32'h0001_0000, 1'b0);
    check("flush_op cycle0 stall", 64'(stall_o), 64'd1);
    repeat (9) drive(F_MULTU, 1'b1, 32'h0001_0000, 32'h0001_0000, 1'b0);
    check("flush_op cycle9 stall", 64'(stall_o), 64'd1);
    drive(F_MULTU, 1'b1, 32'h0001_0000, 32'h0001_0000, 1'b1);
    check("flush cycle stall", 64'(stall_o), 64'd0);
    drive(6'h00, 1'b0, '0, '0, 1'b0);
    check("after flush stall", 64'(stall_o), 64'd0);
    repeat (40) drive(6'h00, 1'b0, '0, '0, 1'b0);
    check("after flush hi", 64'(hi_o), 64'(exp_hi));
    check("after flush lo", 64'(lo_o), 64'(exp_lo));

    // Random multiply/divide traffic
    for (int i = 0; i < 24; i++) begin
      rf = F_MULT + 6'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'h0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
      run_op(rf, ra, rb, $sformatf("rand%0d f=%0h a=%0h b=%0h", i, rf, ra, rb));
    end

    // Reset in the middle of a divide
    drive(F_MTHI, 1'b1, 32'hA5A5_A5A5, '0, 1'b0);
    drive(F_MTLO, 1'b1, 32'h5A5A_5A5A, '0, 1'b0);
    drive(F_DIV, 1'b1, 32'h7654_3210, 32'h0000_0123, 1'b0);
    repeat (5) drive(F_DIV, 1'b1, 32'h7654_3210, 32'h0000_0123, 1'b0);
    check("div running before reset", 64'(stall_o), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    valid_i = 1'b0;
    #1;
    check("mid-op reset stall", 64'(stall_o), 64'd0);
    check("mid-op reset hi", 64'(hi_o), 64'd0);
    check("mid-op reset lo", 64'(lo_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_hi = '0;
    exp_lo = '0;
    repeat (40) drive(6'h00, 1'b0, '0, '0, 1'b0);
    check("post reset lo", 64'(lo_o), 64'd0);
    run_op(F_DIVU, 32'd100, 32'd7, "post_reset_divu");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
